// File: rtl/sign_hash_seq.sv
// Ed25519 signing-side sequencer for hash_wrap: H(sk), H(h,M), H(R,A,M), scalar clamp.
// Optional digest-wait timeout enabled by defining HASH_SEQ_TIMEOUT_EN.
module sign_hash_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] sk,
    input  logic [255:0] msg,
    input  logic [255:0] pk_A,
    input  logic [255:0] R_in,
    input  logic         R_valid,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code,
    output logic [255:0] a_out,
    output logic [511:0] r_digest,
    output logic         r_valid,
    output logic [511:0] k_digest,
    output logic         hw_ena,
    output logic [1:0]   hw_mode,
    output logic [255:0] hw_sk,
    output logic [255:0] hw_h,
    output logic [255:0] hw_R,
    output logic [255:0] hw_A,
    output logic [255:0] hw_M,
    input  logic         hw_ready,
    input  logic         hw_error,
    input  logic         hw_digest_valid,
    input  logic [511:0] hw_digest
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SK_REQ  = 4'd1,
        ST_SK_WAIT = 4'd2,
        ST_HM_REQ  = 4'd3,
        ST_HM_WAIT = 4'd4,
        ST_R_WAIT  = 4'd5,
        ST_K_REQ   = 4'd6,
        ST_K_WAIT  = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    localparam logic [1:0] ERR_HW      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    state_t       state_r;
    logic [255:0] msg_r;
    logic [255:0] pk_r;
    logic         tmo_hit_s;

    // Byte 0 of the scalar is digest[511:504], which lands in a_src[255:248].
    function automatic logic [255:0] clamp_scalar(input logic [255:0] a_src);
        logic [255:0] a;
        a          = a_src;
        a[250:248] = 3'b000;
        a[7]       = 1'b0;
        a[6]       = 1'b1;
        return a;
    endfunction

`ifdef HASH_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    logic [15:0] tmo_cnt_r;
    logic        in_wait_s;

    assign in_wait_s = (state_r == ST_SK_WAIT) || (state_r == ST_HM_WAIT) ||
                       (state_r == ST_K_WAIT);
    assign tmo_hit_s = in_wait_s && (tmo_cnt_r == TMO_LAST);

    // Digest-wait cycle counter, zero outside the hash wait states.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= 16'd0;
        end else if (!in_wait_s) begin
            tmo_cnt_r <= 16'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end
    end
`else
    logic unused_tmo_s;
    assign tmo_hit_s    = 1'b0;
    assign unused_tmo_s = (TIMEOUT_CYCLES == 32'd0);
`endif

    // The request strobe follows hw_ready directly so the handshake costs one cycle.
    assign hw_ena = hw_ready &&
                    ((state_r == ST_SK_REQ) || (state_r == ST_HM_REQ) || (state_r == ST_K_REQ));

    // Sequencer FSM with registered outputs and hash operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            msg_r    <= 256'd0;
            pk_r     <= 256'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            a_out    <= 256'd0;
            r_digest <= 512'd0;
            r_valid  <= 1'b0;
            k_digest <= 512'd0;
            hw_mode  <= 2'd0;
            hw_sk    <= 256'd0;
            hw_h     <= 256'd0;
            hw_R     <= 256'd0;
            hw_A     <= 256'd0;
            hw_M     <= 256'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        msg_r    <= msg;
                        pk_r     <= pk_A;
                        err      <= 1'b0;
                        err_code <= 2'd0;
                        busy     <= 1'b1;
                        hw_mode  <= 2'd0;
                        hw_sk    <= sk;
                        state_r  <= ST_SK_REQ;
                    end
                end
                ST_SK_REQ, ST_HM_REQ, ST_K_REQ: begin
                    if (hw_ready && hw_error) begin
                        err      <= 1'b1;
                        err_code <= ERR_HW;
                        state_r  <= ST_ERR;
                    end else if (hw_ready) begin
                        case (state_r)
                            ST_SK_REQ: state_r <= ST_SK_WAIT;
                            ST_HM_REQ: state_r <= ST_HM_WAIT;
                            default:   state_r <= ST_K_WAIT;
                        endcase
                    end
                end
                ST_SK_WAIT, ST_HM_WAIT, ST_K_WAIT: begin
                    if (hw_digest_valid) begin
                        case (state_r)
                            ST_SK_WAIT: begin
                                a_out   <= clamp_scalar(hw_digest[511:256]);
                                hw_mode <= 2'd1;
                                hw_sk   <= 256'd0;
                                hw_h    <= hw_digest[255:0];
                                hw_M    <= msg_r;
                                state_r <= ST_HM_REQ;
                            end
                            ST_HM_WAIT: begin
                                r_digest <= hw_digest;
                                r_valid  <= 1'b1;
                                hw_mode  <= 2'd0;
                                hw_h     <= 256'd0;
                                hw_M     <= 256'd0;
                                state_r  <= ST_R_WAIT;
                            end
                            default: begin
                                k_digest <= hw_digest;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                hw_mode  <= 2'd0;
                                hw_R     <= 256'd0;
                                hw_A     <= 256'd0;
                                hw_M     <= 256'd0;
                                state_r  <= ST_IDLE;
                            end
                        endcase
                    end else if (tmo_hit_s) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state_r  <= ST_ERR;
                    end
                end
                ST_R_WAIT: begin
                    if (R_valid) begin
                        r_valid <= 1'b0;
                        hw_mode <= 2'd2;
                        hw_R    <= R_in;
                        hw_A    <= pk_r;
                        hw_M    <= msg_r;
                        state_r <= ST_K_REQ;
                    end
                end
                ST_ERR: begin
                    busy    <= 1'b0;
                    hw_mode <= 2'd0;
                    hw_sk   <= 256'd0;
                    hw_h    <= 256'd0;
                    hw_R    <= 256'd0;
                    hw_A    <= 256'd0;
                    hw_M    <= 256'd0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_hash_seq.sv
// Randomized bench for sign_hash_seq: the bench plays hash_wrap and the point-mult engine
// and checks requests and results against an Ed25519-level reference of the sequence.
module tb_sign_hash_seq;

    logic         clk = 1'b0;
    logic         rst, start, R_valid, hw_ready, hw_error, hw_digest_valid;
    logic [255:0] sk, msg, pk_A, R_in;
    logic [511:0] hw_digest;
    logic         busy, done, err, r_valid, hw_ena;
    logic [1:0]   err_code, hw_mode;
    logic [255:0] a_out, hw_sk, hw_h, hw_R, hw_A, hw_M;
    logic [511:0] r_digest, k_digest;

    int n_checks = 0;
    int n_errors = 0;
    int ena_cnt  = 0;
    int done_cnt = 0;

    sign_hash_seq dut (
        .clk(clk), .rst(rst), .start(start), .sk(sk), .msg(msg), .pk_A(pk_A),
        .R_in(R_in), .R_valid(R_valid), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .a_out(a_out), .r_digest(r_digest), .r_valid(r_valid),
        .k_digest(k_digest), .hw_ena(hw_ena), .hw_mode(hw_mode), .hw_sk(hw_sk),
        .hw_h(hw_h), .hw_R(hw_R), .hw_A(hw_A), .hw_M(hw_M), .hw_ready(hw_ready),
        .hw_error(hw_error), .hw_digest_valid(hw_digest_valid), .hw_digest(hw_digest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (hw_ena === 1'b1) ena_cnt <= ena_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], $urandom()};
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [511:0] r = rnd512();
        return r[255:0];
    endfunction

    // RFC 8032 clamp on the first 32 digest bytes (byte 0 = digest[511:504]).
    function automatic logic [255:0] clamp_ref(input logic [511:0] d);
        logic [7:0]   b [32];
        logic [255:0] a = '0;
        for (int i = 0; i < 32; i++) b[i] = d[511-8*i -: 8];
        b[0]  = b[0] & 8'd248;
        b[31] = (b[31] & 8'd127) | 8'd64;
        for (int i = 0; i < 32; i++) a = {a[247:0], b[i]};
        return a;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, {err, err_code}, 3'd0);
        check({tag, "_rvalid"}, r_valid, 1'b0);
        check({tag, "_a"}, a_out, 256'd0);
        check({tag, "_rdig"}, r_digest, 512'd0);
        check({tag, "_kdig"}, k_digest, 512'd0);
        check({tag, "_hwops"}, hw_sk | hw_h | hw_R | hw_A | hw_M, 256'd0);
        check({tag, "_hwmode"}, {hw_ena, hw_mode}, 3'd0);
    endtask

    // Acts as an idle hash_wrap: raise ready, expect one request with the given operands.
    task automatic serve_req(input logic [1:0] m, input logic [255:0] e_sk, e_h, e_R, e_A, e_M,
                             input bit inj_err);
        hw_ready = 1'b1;
        hw_error = inj_err;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (hw_ena === 1'b1) break;
            @(posedge clk); #1;
        end
        check("req_ena", hw_ena, 1'b1);
        check("req_mode", hw_mode, m);
        check("req_sk", hw_sk, e_sk);
        check("req_h", hw_h, e_h);
        check("req_R", hw_R, e_R);
        check("req_A", hw_A, e_A);
        check("req_M", hw_M, e_M);
        @(posedge clk); #1;
        hw_ready = 1'b0;
        hw_error = 1'b0;
    endtask

    // Returns a digest after a random latency; optionally pokes start mid-wait.
    task automatic serve_digest(input logic [511:0] d, input bit noise);
        int lat = $urandom_range(0, 4);
        if (noise) begin
            start = 1'b1; msg = ~msg; pk_A = ~pk_A;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (lat) begin
            check("wait_ena", hw_ena, 1'b0);
            @(posedge clk); #1;
        end
        hw_digest_valid = 1'b1;
        hw_digest = d;
        @(posedge clk); #1;
        hw_digest_valid = 1'b0;
        hw_digest = rnd512();
    endtask

    task automatic run_sign(input int stall, input bit err_hm, input bit noise, input bit rst_k);
        logic [255:0] s, m, p, r;
        logic [511:0] d0, d1, d2;
        int e0, dn0;
        s = rnd256(); m = rnd256(); p = rnd256(); r = rnd256();
        d0 = rnd512(); d1 = rnd512(); d2 = rnd512();
        e0 = ena_cnt; dn0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; sk = s; msg = m; pk_A = p;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_errclr", {err, err_code}, 3'd0);
        hw_ready = 1'b0;
        repeat (stall) begin
            #1 check("stall_ena", hw_ena, 1'b0);
            @(posedge clk); #1;
        end
        serve_req(2'd0, s, 256'd0, 256'd0, 256'd0, 256'd0, 1'b0);
        serve_digest(d0, 1'b0);
        check("clamp_a", a_out, clamp_ref(d0));
        check("clamp_bits", {a_out[250:248], a_out[7:6]}, 5'b00001);
        serve_req(2'd1, 256'd0, d0[255:0], 256'd0, 256'd0, m, err_hm);
        if (err_hm) begin
            check("err_flag", {err, err_code, busy}, 4'b1011);
            @(posedge clk); #1;
            check("err_idle", {err, err_code, busy}, 4'b1010);
            check("err_enas", ena_cnt - e0, 2);
            return;
        end
        serve_digest(d1, noise);
        check("rwait_valid", r_valid, 1'b1);
        check("r_digest", r_digest, d1);
        if (noise) begin
            start = 1'b1; msg = ~msg; pk_A = ~pk_A;
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 start = 1'b0;
        check("rwait_hold", {r_valid, busy}, 2'b11);
        R_valid = 1'b1; R_in = r;
        @(posedge clk); #1;
        R_valid = 1'b0; R_in = rnd256();
        check("rvalid_drop", r_valid, 1'b0);
        serve_req(2'd2, 256'd0, 256'd0, r, p, m, 1'b0);
        if (rst_k) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_reset_state("rst_kwait");
            check("rst_enas", ena_cnt - e0, 3);
            return;
        end
        serve_digest(d2, 1'b0);
        check("done_pulse", {done, busy}, 2'b10);
        check("k_digest", k_digest, d2);
        check("final_a", a_out, clamp_ref(d0));
        check("final_r", r_digest, d1);
        @(posedge clk); #1;
        check("done_drop", done, 1'b0);
        check("done_count", done_cnt - dn0, 1);
        check("ena_count", ena_cnt - e0, 3);
        check("hold_k", k_digest, d2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; R_valid = 1'b0; hw_ready = 1'b0; hw_error = 1'b0;
        hw_digest_valid = 1'b0; sk = '0; msg = '0; pk_A = '0; R_in = '0; hw_digest = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // Stray digest strobe while idle must be ignored.
        hw_digest_valid = 1'b1; hw_digest = rnd512();
        @(posedge clk); #1;
        hw_digest_valid = 1'b0;
        check("idle_dv", {busy, r_digest[0], a_out[0]}, 3'd0);

        run_sign(10, 1'b0, 1'b0, 1'b0);
        run_sign(0, 1'b1, 1'b0, 1'b0);
        run_sign(2, 1'b0, 1'b1, 1'b0);
        run_sign(1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            run_sign($urandom_range(0, 3), 1'b0, ($urandom_range(0, 1) == 1), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
